// File: rtl/fetch_controller.sv
// Fetch controller: owns the fetch PC, reads one word per cycle from a
// combinational instruction ROM, and buffers {pc, instr} pairs in a small
// prefetch FIFO that decode drains over a valid/ready handshake.
// Redirects flush the FIFO. Misaligned or out-of-range targets, and running
// sequentially off the end of the ROM, park the fetcher in a fault state.
// Optional macro FETCH_PERF_EN adds push and stall performance counters.
module fetch_controller #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned ROM_BYTES = 1024,
    parameter int unsigned DEPTH     = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] mem_addr_o,
    input  logic [31:0] mem_instr_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        fault_o,
    output logic [31:0] fault_pc_o
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched_o,
    output logic [31:0] perf_stall_o
`endif
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [31:0] LAST_PC = 32'(ROM_BYTES - 4);
    localparam logic [31:0] END_PC  = 32'(ROM_BYTES);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    typedef enum logic [0:0] {
        StRun,
        StFault
    } state_e;

    state_e      state;
    logic [31:0] fetch_pc;
    logic [31:0] fault_pc;

    logic [31:0] pc_mem    [DEPTH];
    logic [31:0] instr_mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    logic empty;
    logic full;
    logic pop;
    logic push;
    logic redirect_bad;

    // FIFO status from the extra pointer MSB; handshake and push decisions.
    always_comb begin
        empty        = (wr_ptr == rd_ptr);
        full         = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        // A redirect discards any pop in the same cycle.
        pop          = !empty && ready_i && !redirect_i;
        // Full FIFO still accepts a word when the head leaves this cycle.
        push         = (state == StRun) && !redirect_i && (!full || pop);
        redirect_bad = (redirect_pc_i[1:0] != 2'b00) || (redirect_pc_i > LAST_PC);
    end

    // Head of FIFO and status outputs, all derived from registered state.
    always_comb begin
        valid_o    = !empty;
        instr_o    = empty ? 32'h0 : instr_mem[rd_ptr[AW-1:0]];
        pc_o       = empty ? 32'h0 : pc_mem[rd_ptr[AW-1:0]];
        fault_o    = (state == StFault);
        fault_pc_o = fault_pc;
        mem_addr_o = fetch_pc;
    end

    // Fetch FSM: PC sequencing, redirects and fault capture.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= StRun;
            fetch_pc <= RESET_PC;
            fault_pc <= 32'h0;
        end else if (redirect_i) begin
            if (redirect_bad) begin
                state    <= StFault;
                fault_pc <= redirect_pc_i;
            end else begin
                state    <= StRun;
                fetch_pc <= redirect_pc_i;
                fault_pc <= 32'h0;
            end
        end else if (push) begin
            // The last ROM word is still delivered; the PC then parks on it so
            // the memory address never leaves the ROM.
            if (fetch_pc == LAST_PC) begin
                state    <= StFault;
                fault_pc <= END_PC;
            end else begin
                fetch_pc <= fetch_pc + 32'd4;
            end
        end
    end

    // FIFO pointers; reset and redirect both empty the buffer.
    always_ff @(posedge clk_i) begin
        if (rst_i || redirect_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // FIFO storage; contents are don't-care while the slot is not valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_mem[wr_ptr[AW-1:0]]    <= fetch_pc;
            instr_mem[wr_ptr[AW-1:0]] <= mem_instr_i;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;

    // Performance counters survive redirects; only reset clears them.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_fetched <= 32'h0;
            perf_stall   <= 32'h0;
        end else begin
            if (push) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if ((state == StRun) && full && !pop) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end

    assign perf_fetched_o = perf_fetched;
    assign perf_stall_o   = perf_stall;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller: directed phases push expected
// {pc, instr} pairs; a negedge monitor pops and compares on each handshake.
module tb_fetch_controller;

    logic        clk;
    logic        rst;
    logic [31:0] mem_addr;
    logic [31:0] mem_instr;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
    logic        ready;
    logic        fault;
    logic [31:0] fault_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_instr_q[$];
    logic [31:0] max_addr = 32'h0;

    fetch_controller dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .mem_addr_o    (mem_addr),
        .mem_instr_i   (mem_instr),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .instr_o       (instr),
        .pc_o          (pc),
        .valid_o       (valid),
        .ready_i       (ready),
        .fault_o       (fault),
        .fault_pc_o    (fault_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched_o(perf_fetched),
        .perf_stall_o  (perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction ROM model.
    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'd0:   rom = 32'h0040_2103;
            32'd4:   rom = 32'h0040_0183;
            32'd8:   rom = 32'h0040_1203;
            32'd24:  rom = 32'h5555_5637;
            default: rom = (a > 32'd1020) ? 32'hDEAD_DEAD : (32'hA000_0000 | a);
        endcase
    endfunction

    assign mem_instr = rom(mem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_word(input logic [31:0] a);
        exp_pc_q.push_back(a);
        exp_instr_q.push_back(rom(a));
    endtask

    // Monitor: compare every accepted head against the scoreboard.
    always @(negedge clk) begin
        if (!rst && mem_addr > max_addr) max_addr = mem_addr;
        if (!rst && valid && ready && !redirect) begin
            if (exp_pc_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: pc %h instr %h with empty scoreboard", pc, instr);
            end else begin
                check("pop_pc", pc, exp_pc_q.pop_front());
                check("pop_instr", instr, exp_instr_q.pop_front());
            end
        end
    end

    // Called at posedge+1; applies reset for one edge and checks reset values.
    task automatic do_reset();
        rst = 1'b1;
        ready = 1'b0;
        redirect = 1'b0;
        exp_pc_q.delete();
        exp_instr_q.delete();
        @(posedge clk);
        #1;
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc", pc, 32'h0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_fault_pc", fault_pc, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
`ifdef FETCH_PERF_EN
        check("rst_perf_fetched", perf_fetched, 32'h0);
        check("rst_perf_stall", perf_stall, 32'h0);
`endif
        rst = 1'b0;
    endtask

    // Called at posedge+1; pulses redirect for one edge.
    task automatic do_redirect(input logic [31:0] target);
        redirect = 1'b1;
        redirect_pc = target;
        @(posedge clk);
        #1;
        redirect = 1'b0;
    endtask

    // Raise ready until the scoreboard empties; returns negedges spent.
    task automatic drain(output int cyc);
        cyc = 0;
        ready = 1'b1;
        while (exp_pc_q.size() != 0 && cyc < 50) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        if (exp_pc_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d entries left after %0d cycles", exp_pc_q.size(), cyc);
            exp_pc_q.delete();
            exp_instr_q.delete();
        end
        @(posedge clk);
        #1;
        ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst = 1'b1;
        ready = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'h0;

        // Phase 1: first word valid one edge after release, then stream.
        do_reset();
        expect_word(32'd0);
        expect_word(32'd4);
        expect_word(32'd8);
        @(posedge clk);
        #1;
        check("p1_first_valid", 32'(valid), 32'd1);
        check("p1_first_pc", pc, 32'd0);
        drain(cyc);
        check("p1_consecutive", 32'(cyc), 32'd3);

        // Phase 2: fill with ready low, then drain back-to-back.
        do_reset();
        repeat (10) @(posedge clk);
        #1;
        check("p2_full_mem_addr", mem_addr, 32'd16);
        check("p2_full_valid", 32'(valid), 32'd1);
        check("p2_full_head", pc, 32'd0);
        for (int i = 0; i < 5; i++) expect_word(32'(4 * i));
        drain(cyc);
        check("p2_no_gaps", 32'(cyc), 32'd5);

        // Phase 3: FIFO holds 4..16, redirect to 24 flushes it.
        do_reset();
        repeat (6) @(posedge clk);
        #1;
        expect_word(32'd0);
        ready = 1'b1;
        @(posedge clk);
        #1;
        ready = 1'b0;
        check("p3_head_before", pc, 32'd4);
        do_redirect(32'd24);
        check("p3_flush_valid", 32'(valid), 32'd0);
        expect_word(32'd24);
        expect_word(32'd28);
        drain(cyc);
        check("p3_redirect_latency", 32'(cyc), 32'd3);

        // Phase 4: misaligned redirect faults; legal redirect recovers.
        do_redirect(32'd26);
        check("p4_fault", 32'(fault), 32'd1);
        check("p4_fault_pc", fault_pc, 32'd26);
        check("p4_valid", 32'(valid), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("p4_valid_held", 32'(valid), 32'd0);
        check("p4_fault_held", 32'(fault), 32'd1);
        do_redirect(32'd0);
        check("p4_fault_clear", 32'(fault), 32'd0);
        expect_word(32'd0);
        expect_word(32'd4);
        drain(cyc);
        check("p4_resume", 32'(cyc), 32'd3);

        // Phase 5: sequential run off the end of the ROM.
        do_redirect(32'd1012);
        check("p5_flush_valid", 32'(valid), 32'd0);
        repeat (6) @(posedge clk);
        #1;
        check("p5_fault", 32'(fault), 32'd1);
        check("p5_fault_pc", fault_pc, 32'd1024);
        check("p5_mem_addr", mem_addr, 32'd1020);
        check("p5_valid", 32'(valid), 32'd1);
        expect_word(32'd1012);
        expect_word(32'd1016);
        expect_word(32'd1020);
        drain(cyc);
        check("p5_drain", 32'(cyc), 32'd3);
        check("p5_empty_after", 32'(valid), 32'd0);
        check("p5_fault_after", 32'(fault), 32'd1);

        // Phase 6: full FIFO and fault, then reset.
        do_redirect(32'd1008);
        repeat (8) @(posedge clk);
        #1;
        check("p6_fault", 32'(fault), 32'd1);
        check("p6_valid", 32'(valid), 32'd1);
        check("p6_head", pc, 32'd1008);
        do_reset();

        check("scoreboard_empty", 32'(exp_pc_q.size()), 32'd0);
        check("max_mem_addr_in_rom", 32'(max_addr <= 32'd1020), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
